// File: rtl/datapath_pkg.sv
// Shared datapath definitions: register address width, architectural register
// count, write-back source encoding and the register index helper.
package datapath_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 8;
    localparam int REG_IDX_W  = $clog2(NREGS);

    typedef enum logic [0:0] {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

    // The register file decodes only the low bits of a destination address.
    function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [REG_ADDR_W-1:0] addr);
        return addr[REG_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/load_tag_fifo.sv
// Circular buffer of outstanding load destinations, exposing every entry so the
// top level can build the pending-register scoreboard.
module load_tag_fifo
    import datapath_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [REG_ADDR_W-1:0]            i_dest,
    output logic [REG_ADDR_W-1:0]            o_head,
    output logic                             o_empty,
    output logic                             o_full,
    output logic [DEPTH-1:0]                 o_entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_entry_dest
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]                      wr_ptr_r;
    logic [AW:0]                      rd_ptr_r;
    logic [AW:0]                      count_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] mem_r;

    // Pointer and storage update; callers only push when there is room.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            mem_r    <= '0;
        end else begin
            if (i_push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= i_dest;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (i_pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy flags and per-entry valid: an entry is live when its distance
    // from the read pointer is below the occupancy.
    always_comb begin
        count_s       = wr_ptr_r - rd_ptr_r;
        o_empty       = (wr_ptr_r == rd_ptr_r);
        o_full        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        o_head        = mem_r[rd_ptr_r[AW-1:0]];
        o_entry_dest  = mem_r;
        o_entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_valid[i] = ({1'b0, (AW'(i) - rd_ptr_r[AW-1:0])} < count_s);
        end
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-port controller merging ALU results with in-order load
// responses, plus a pending-load scoreboard for hazard detection.
module writeback_ctrl
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int NREGS = datapath_pkg::NREGS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_dest,
    input  logic [WIDTH-1:0]      i_alu_result,
    input  logic                  i_ld_issue,
    input  logic [REG_ADDR_W-1:0] i_ld_dest,
    output logic                  o_ld_full,
    input  logic                  i_mem_valid,
    input  logic [WIDTH-1:0]      i_mem_rdata,
    output logic                  o_regwrite,
    output logic                  o_memtoreg,
    output logic [REG_ADDR_W-1:0] o_RegD_addr,
    output logic [WIDTH-1:0]      o_ALUout,
    output logic [WIDTH-1:0]      o_Memdata,
    output logic [NREGS-1:0]      o_pending,
    output logic                  o_err
);

    localparam int IDX_W = $clog2(NREGS);

    logic                             fifo_empty_s;
    logic                             fifo_full_s;
    logic [REG_ADDR_W-1:0]            head_dest_s;
    logic [DEPTH-1:0]                 entry_valid_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_dest_s;
    logic                             pop_s;
    logic                             push_s;
    logic                             alu_fire_s;
    logic                             proto_err_s;

    logic                             s1_valid_r;
    logic [REG_ADDR_W-1:0]            s1_dest_r;
    logic                             s2_valid_r;
    logic [REG_ADDR_W-1:0]            s2_dest_r;
    logic                             alu_ready_r;
    logic                             err_r;
    logic [WIDTH-1:0]                 memdata_r;

    logic                             slot_valid_s;
    wb_src_t                          slot_src_s;
    logic [REG_ADDR_W-1:0]            slot_dest_s;

    logic                             regwrite_r;
    logic                             memtoreg_r;
    logic [REG_ADDR_W-1:0]            regd_addr_r;
    logic [WIDTH-1:0]                 aluout_r;
    logic [NREGS-1:0]                 pending_s;

    load_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_push        (push_s),
        .i_pop         (pop_s),
        .i_dest        (i_ld_dest),
        .o_head        (head_dest_s),
        .o_empty       (fifo_empty_s),
        .o_full        (fifo_full_s),
        .o_entry_valid (entry_valid_s),
        .o_entry_dest  (entry_dest_s)
    );

    // Handshake qualification; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop_s       = i_mem_valid & ~fifo_empty_s;
        push_s      = i_ld_issue & (~fifo_full_s | pop_s);
        alu_fire_s  = i_alu_valid & alu_ready_r;
        proto_err_s = (i_ld_issue & fifo_full_s & ~pop_s) | (i_mem_valid & fifo_empty_s);
    end

    // Load pipeline, ALU back-pressure flag and sticky error.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_r  <= 1'b0;
            s1_dest_r   <= '0;
            s2_valid_r  <= 1'b0;
            s2_dest_r   <= '0;
            alu_ready_r <= 1'b1;
            err_r       <= 1'b0;
            memdata_r   <= '0;
        end else begin
            s1_valid_r  <= pop_s;
            if (pop_s) begin
                s1_dest_r <= head_dest_s;
                memdata_r <= i_mem_rdata;
            end
            s2_valid_r  <= s1_valid_r & (reg_idx(s1_dest_r) != '0);
            s2_dest_r   <= s1_dest_r;
            // Blocking the ALU the cycle after a pop leaves the load's write slot free.
            alu_ready_r <= ~pop_s;
            if (proto_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Pick the source for next cycle's write slot; a load in stage 1 always wins.
    always_comb begin
        slot_valid_s = 1'b0;
        slot_src_s   = WB_ALU;
        slot_dest_s  = i_alu_dest;
        if (s1_valid_r) begin
            slot_valid_s = 1'b1;
            slot_src_s   = WB_MEM;
            slot_dest_s  = s1_dest_r;
        end else if (alu_fire_s) begin
            slot_valid_s = 1'b1;
            slot_src_s   = WB_ALU;
            slot_dest_s  = i_alu_dest;
        end else begin
            slot_valid_s = 1'b0;
            slot_src_s   = WB_ALU;
            slot_dest_s  = i_alu_dest;
        end
    end

    // Registered write port; register 0 consumes the slot without enabling the write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            regwrite_r  <= 1'b0;
            memtoreg_r  <= 1'b0;
            regd_addr_r <= '0;
            aluout_r    <= '0;
        end else begin
            regwrite_r <= slot_valid_s & (reg_idx(slot_dest_s) != '0);
            memtoreg_r <= slot_valid_s & (slot_src_s == WB_MEM);
            if (slot_valid_s) begin
                regd_addr_r <= slot_dest_s;
                case (slot_src_s)
                    WB_ALU:  aluout_r <= i_alu_result;
                    WB_MEM:  aluout_r <= aluout_r;
                    default: aluout_r <= aluout_r;
                endcase
            end
        end
    end

    // Pending scoreboard over queued tags, stage 1 and the write in progress.
    always_comb begin
        pending_s = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                pending_s[r] = pending_s[r] |
                               (entry_valid_s[e] & (reg_idx(entry_dest_s[e]) == IDX_W'(r)));
            end
            pending_s[r] = pending_s[r] |
                           (s1_valid_r & (reg_idx(s1_dest_r) == IDX_W'(r))) |
                           (s2_valid_r & (reg_idx(s2_dest_r) == IDX_W'(r)));
        end
    end

    assign o_alu_ready = alu_ready_r;
    assign o_ld_full   = fifo_full_s;
    assign o_regwrite  = regwrite_r;
    assign o_memtoreg  = memtoreg_r;
    assign o_RegD_addr = regd_addr_r;
    assign o_ALUout    = aluout_r;
    assign o_Memdata   = memdata_r;
    assign o_pending   = pending_s;
    assign o_err       = err_r;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Randomized scoreboard bench for writeback_ctrl with a queue-based reference model.
module tb_writeback_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int NREGS = 8;
    localparam int NCYC  = 4096;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_alu_valid = 1'b0;
    logic             o_alu_ready;
    logic [4:0]       i_alu_dest = 5'd0;
    logic [WIDTH-1:0] i_alu_result = 32'd0;
    logic             i_ld_issue = 1'b0;
    logic [4:0]       i_ld_dest = 5'd0;
    logic             o_ld_full;
    logic             i_mem_valid = 1'b0;
    logic [WIDTH-1:0] i_mem_rdata = 32'd0;
    logic             o_regwrite;
    logic             o_memtoreg;
    logic [4:0]       o_RegD_addr;
    logic [WIDTH-1:0] o_ALUout;
    logic [WIDTH-1:0] o_Memdata;
    logic [NREGS-1:0] o_pending;
    logic             o_err;

    writeback_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_dest(i_alu_dest), .i_alu_result(i_alu_result),
        .i_ld_issue(i_ld_issue), .i_ld_dest(i_ld_dest), .o_ld_full(o_ld_full),
        .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata),
        .o_regwrite(o_regwrite), .o_memtoreg(o_memtoreg), .o_RegD_addr(o_RegD_addr),
        .o_ALUout(o_ALUout), .o_Memdata(o_Memdata), .o_pending(o_pending), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         cyc;
        bit         mem;
        logic [4:0] dest;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int         wcyc;
        logic [4:0] dest;
    } fly_t;

    // reference model state
    wr_t        sb[$];
    logic [4:0] mq[$];
    fly_t       fly[$];
    bit         m_pop_prev = 1'b0;
    bit         m_err = 1'b0;
    bit         exp_ready [NCYC];
    bit         exp_full  [NCYC];
    bit         exp_errv  [NCYC];
    bit         exp_m2r   [NCYC];
    logic [7:0] exp_pend  [NCYC];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] prev_memdata = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model_pending(input int k);
        logic [7:0] p;
        p = 8'd0;
        foreach (mq[i]) if ((int'(mq[i]) % NREGS) != 0) p[int'(mq[i]) % NREGS] = 1'b1;
        foreach (fly[i]) if (fly[i].wcyc >= k && (int'(fly[i].dest) % NREGS) != 0)
            p[int'(fly[i].dest) % NREGS] = 1'b1;
        return p;
    endfunction

    // Apply the behavioural rules to this cycle's inputs; fills expectations for k+1 / k+2.
    task automatic model_step(input int k);
        bit ready, pop;
        logic [4:0] d;
        ready = !m_pop_prev;
        pop   = i_mem_valid && (mq.size() > 0);
        if (i_mem_valid && mq.size() == 0) m_err = 1'b1;
        if (i_alu_valid && ready && (int'(i_alu_dest) % NREGS) != 0)
            sb.push_back('{k + 1, 1'b0, i_alu_dest, i_alu_result});
        if (pop) begin
            d = mq.pop_front();
            exp_m2r[k + 2] = 1'b1;
            fly.push_back('{k + 2, d});
            if ((int'(d) % NREGS) != 0) sb.push_back('{k + 2, 1'b1, d, i_mem_rdata});
        end
        if (i_ld_issue) begin
            if (mq.size() < DEPTH) mq.push_back(i_ld_dest);
            else m_err = 1'b1;
        end
        m_pop_prev = pop;
        while (fly.size() > 0 && fly[0].wcyc < k + 1) void'(fly.pop_front());
        exp_ready[k + 1] = !pop;
        exp_full[k + 1]  = (mq.size() == DEPTH);
        exp_errv[k + 1]  = m_err;
        exp_pend[k + 1]  = model_pending(k + 1);
    endtask

    task automatic model_reset(input int k);
        sb.delete();
        mq.delete();
        fly.delete();
        m_pop_prev = 1'b0;
        m_err = 1'b0;
        exp_m2r[k + 1] = 1'b0;
        exp_m2r[k + 2] = 1'b0;
        exp_ready[k + 1] = 1'b1;
        exp_full[k + 1]  = 1'b0;
        exp_errv[k + 1]  = 1'b0;
        exp_pend[k + 1]  = 8'd0;
    endtask

    task automatic cyc_in(input bit rst, input bit av, input logic [4:0] ad, input logic [31:0] ar,
                          input bit li, input logic [4:0] ld, input bit mv, input logic [31:0] md);
        i_reset = rst; i_alu_valid = av; i_alu_dest = ad; i_alu_result = ar;
        i_ld_issue = li; i_ld_dest = ld; i_mem_valid = mv; i_mem_rdata = md;
        if (rst) model_reset(cyc);
        else model_step(cyc);
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic rand_phase(input int n, input int ld_pct, input int mem_pct);
        for (int i = 0; i < n; i++) begin
            bit mv, li;
            mv = (mq.size() > 0) && ($urandom_range(0, 99) < mem_pct);
            li = ($urandom_range(0, 99) < ld_pct) && ((mq.size() < DEPTH) || mv);
            cyc_in(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   li, 5'($urandom_range(0, 15)), mv, $urandom);
        end
    endtask

    // Monitor: reset values while in reset, otherwise model expectations and scoreboard pops.
    initial begin
        wr_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                chk("rst_regwrite", 32'(o_regwrite), 32'd0);
                chk("rst_memtoreg", 32'(o_memtoreg), 32'd0);
                chk("rst_addr", 32'(o_RegD_addr), 32'd0);
                chk("rst_aluout", o_ALUout, 32'd0);
                chk("rst_memdata", o_Memdata, 32'd0);
                chk("rst_pending", 32'(o_pending), 32'd0);
                chk("rst_err", 32'(o_err), 32'd0);
                chk("rst_full", 32'(o_ld_full), 32'd0);
                chk("rst_ready", 32'(o_alu_ready), 32'd1);
            end else begin
                chk("alu_ready", 32'(o_alu_ready), 32'(exp_ready[cyc]));
                chk("ld_full", 32'(o_ld_full), 32'(exp_full[cyc]));
                chk("err", 32'(o_err), 32'(exp_errv[cyc]));
                chk("pending", 32'(o_pending), 32'(exp_pend[cyc]));
                chk("memtoreg", 32'(o_memtoreg), 32'(exp_m2r[cyc]));
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_write cyc=%0d got=none want=dest %0d at cycle %0d",
                             cyc, sb[0].dest, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (o_regwrite) begin
                    if (sb.size() == 0 || sb[0].cyc != cyc) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write cyc=%0d got=dest %0d want=no write",
                                 cyc, o_RegD_addr);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_dest", 32'(o_RegD_addr), 32'(e.dest));
                        chk("wr_src", 32'(o_memtoreg), 32'(e.mem));
                        if (e.mem) chk("wr_memdata", prev_memdata, e.data);
                        else chk("wr_aludata", o_ALUout, e.data);
                    end
                end
            end
            prev_memdata = o_Memdata;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        // ALU write, then a single load with pending window
        cyc_in(1'b0, 1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 1'b0, 32'd0);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 32'd0);
        idle(2);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF);
        idle(3);
        // response colliding with a held ALU offer
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 32'd0);
        idle(1);
        cyc_in(1'b0, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0, 1'b1, 32'h1234_5678);
        cyc_in(1'b0, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0, 1'b0, 32'd0);
        cyc_in(1'b0, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0, 1'b0, 32'd0);
        idle(3);
        // error-free random traffic
        rand_phase(200, 60, 30);
        rand_phase(200, 40, 70);
        idle(4);
        // fill, drop, push+pop while full, back-to-back drain
        for (int i = 1; i <= 4; i++) cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b0, 32'd0);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 32'hA000_0001);
        for (int i = 0; i < 4; i++)
            cyc_in(1'b0, 1'b1, 5'd6, 32'h5500_0000 + 32'(i), 1'b0, 5'd0, 1'b1, 32'hB000_0000 + 32'(i));
        idle(3);
        // response with nothing outstanding, register-0 writes (ALU and aliased load)
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hCAFE_0000);
        idle(2);
        cyc_in(1'b0, 1'b1, 5'd0, 32'h0000_00FF, 1'b1, 5'd8, 1'b0, 32'd0);
        idle(1);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h0BAD_0008);
        idle(3);
        // reset between a response and its write
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 32'd0);
        idle(1);
        cyc_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h1111_2222);
        cyc_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        cyc_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        idle(4);
        rand_phase(150, 50, 50);
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
